// File: rtl/alu_sequencer_pkg.sv
// Shared opcode and FSM state encodings for the ALU command sequencer.
package alu_sequencer_pkg;

   typedef enum logic [3:0] {
      OpNop  = 4'd0,
      OpAdd  = 4'd1,
      OpSub  = 4'd2,
      OpMul  = 4'd3,
      OpDiv  = 4'd4,
      OpMod  = 4'd5,
      OpAnd  = 4'd6,
      OpOr   = 4'd7,
      OpXor  = 4'd8,
      OpNot  = 4'd9,
      OpNand = 4'd10,
      OpNor  = 4'd11,
      OpXnor = 4'd12,
      OpShl  = 4'd13,
      OpShr  = 4'd14,
      OpClr  = 4'd15
   } op_e;

   typedef enum logic [1:0] {
      StIdle,
      StMult,
      StDivd,
      StDone
   } state_e;

endpackage

// File: rtl/alu_iter_div.sv
// Unsigned restoring divider: one quotient bit per cycle, WIDTH cycles after start_i.
module alu_iter_div #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             done_o,
   output logic [WIDTH-1:0] quo_o,
   output logic [WIDTH-1:0] rem_o
);

   localparam int unsigned CntW = $clog2(WIDTH);

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             active_q, active_d;
   logic [WIDTH:0]   trial;

   always_comb begin
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      // Shift the next dividend bit into the partial remainder and try the subtraction.
      trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
      if (start_i) begin
         rem_d    = '0;
         quo_d    = dividend_i;
         dvs_d    = divisor_i;
         cnt_d    = '0;
         active_d = 1'b1;
      end else if (active_q) begin
         if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
         end
         cnt_d = cnt_q + CntW'(1);
         if (cnt_q == CntW'(WIDTH - 1)) begin
            active_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else begin
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
      end
   end

   assign done_o = active_q && (cnt_q == CntW'(WIDTH - 1));
   assign quo_o  = quo_q;
   assign rem_o  = rem_q;

endmodule

// File: rtl/alu_sequencer.sv
// Command-level ALU controller: single-cycle arithmetic/logic, iterative MUL and DIV/MOD.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [3:0]         cmd_op,
   input  logic [WIDTH-1:0]   cmd_a,
   input  logic [WIDTH-1:0]   cmd_b,
   input  logic               cmd_use_acc,
   output logic               res_valid,
   output logic [2*WIDTH-1:0] res_data,
   output logic               err_ovf,
   output logic               err_dz,
   output logic               busy
);

   localparam int unsigned ResW = 2 * WIDTH;
   localparam int unsigned CntW = $clog2(WIDTH);

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  opa_q, opa_d;
   logic [WIDTH-1:0]  opb_q, opb_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [ResW-1:0]   acc_q, acc_d;
   logic              ovf_pend_q, ovf_pend_d;
   logic              dz_pend_q, dz_pend_d;
   logic              is_div_q, is_div_d;
   logic              is_mod_q, is_mod_d;
   logic [ResW-1:0]   res_data_q, res_data_d;
   logic              res_valid_q, res_valid_d;
   logic              err_ovf_q, err_ovf_d;
   logic              err_dz_q, err_dz_d;

   op_e               op;
   logic              accept;
   logic [WIDTH-1:0]  a_in;
   logic [WIDTH-1:0]  b_eff;
   logic [WIDTH:0]    addsub;
   logic              ovf;
   logic [WIDTH-1:0]  f_logic;
   logic              div_start;
   logic              div_done;
   logic [WIDTH-1:0]  div_quo;
   logic [WIDTH-1:0]  div_rem;

   assign op     = op_e'(cmd_op);
   assign accept = cmd_valid && (state_q == StIdle);

   // SUB is A + ~B + 1; overflow is carry into the MSB xor carry out of it.
   always_comb begin
      a_in   = cmd_use_acc ? res_data_q[WIDTH-1:0] : cmd_a;
      b_eff  = (op == OpSub) ? ~cmd_b : cmd_b;
      addsub = {1'b0, a_in} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op == OpSub)};
      ovf    = (a_in[WIDTH-1] ^ b_eff[WIDTH-1] ^ addsub[WIDTH-1]) ^ addsub[WIDTH];
   end

   always_comb begin
      f_logic = '0;
      unique case (op)
         OpAnd:   f_logic = a_in & cmd_b;
         OpOr:    f_logic = a_in | cmd_b;
         OpXor:   f_logic = a_in ^ cmd_b;
         OpNot:   f_logic = ~a_in;
         OpNand:  f_logic = ~(a_in & cmd_b);
         OpNor:   f_logic = ~(a_in | cmd_b);
         OpXnor:  f_logic = ~(a_in ^ cmd_b);
         default: f_logic = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      ovf_pend_d  = ovf_pend_q;
      dz_pend_d   = dz_pend_q;
      is_div_d    = is_div_q;
      is_mod_d    = is_mod_q;
      res_data_d  = res_data_q;
      res_valid_d = 1'b0;
      err_ovf_d   = err_ovf_q;
      err_dz_d    = err_dz_q;
      div_start   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               opa_d      = a_in;
               opb_d      = cmd_b;
               cnt_d      = '0;
               ovf_pend_d = 1'b0;
               dz_pend_d  = 1'b0;
               is_div_d   = 1'b0;
               is_mod_d   = (op == OpMod);
               state_d    = StDone;
               unique case (op)
                  OpNop: state_d = StIdle;
                  OpAdd, OpSub: begin
                     acc_d      = {{WIDTH{addsub[WIDTH-1]}}, addsub[WIDTH-1:0]};
                     ovf_pend_d = ovf;
                  end
                  OpMul: begin
                     acc_d   = '0;
                     state_d = StMult;
                  end
                  OpDiv, OpMod: begin
                     acc_d = '0;
                     if (cmd_b == '0) begin
                        dz_pend_d = 1'b1;
                     end else begin
                        div_start = 1'b1;
                        is_div_d  = 1'b1;
                        state_d   = StDivd;
                     end
                  end
                  OpShl: acc_d = {{WIDTH{1'b0}}, a_in} << cmd_b[CntW-1:0];
                  OpShr: acc_d = {{WIDTH{1'b0}}, a_in >> cmd_b[CntW-1:0]};
                  OpClr: begin
                     acc_d = '0;
                     opa_d = '0;
                     opb_d = '0;
                  end
                  default: acc_d = {{WIDTH{1'b0}}, f_logic};
               endcase
            end
         end
         StMult: begin
            if (opb_q[cnt_q]) begin
               acc_d = acc_q + ({{WIDTH{1'b0}}, opa_q} << cnt_q);
            end
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
               state_d = StDone;
            end
         end
         StDivd: begin
            if (div_done) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (is_div_q) begin
               res_data_d = {{WIDTH{1'b0}}, is_mod_q ? div_rem : div_quo};
            end else begin
               res_data_d = acc_q;
            end
            err_ovf_d   = ovf_pend_q;
            err_dz_d    = dz_pend_q;
            res_valid_d = 1'b1;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         opa_q       <= '0;
         opb_q       <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         ovf_pend_q  <= 1'b0;
         dz_pend_q   <= 1'b0;
         is_div_q    <= 1'b0;
         is_mod_q    <= 1'b0;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
         err_ovf_q   <= 1'b0;
         err_dz_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         ovf_pend_q  <= ovf_pend_d;
         dz_pend_q   <= dz_pend_d;
         is_div_q    <= is_div_d;
         is_mod_q    <= is_mod_d;
         res_data_q  <= res_data_d;
         res_valid_q <= res_valid_d;
         err_ovf_q   <= err_ovf_d;
         err_dz_q    <= err_dz_d;
      end
   end

   alu_iter_div #(
      .WIDTH(WIDTH)
   ) u_div (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (div_start),
      .dividend_i (a_in),
      .divisor_i  (cmd_b),
      .done_o     (div_done),
      .quo_o      (div_quo),
      .rem_o      (div_rem)
   );

   assign cmd_ready = (state_q == StIdle);
   assign busy      = ~cmd_ready;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign err_ovf   = err_ovf_q;
   assign err_dz    = err_dz_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: results and error flags, latencies, chaining, reset abort.
module tb_alu_sequencer;

   localparam int OP_NOP = 0, OP_ADD = 1, OP_SUB = 2, OP_MUL = 3, OP_DIV = 4, OP_MOD = 5;
   localparam int OP_AND = 6, OP_OR = 7, OP_XOR = 8, OP_NOT = 9, OP_NAND = 10, OP_NOR = 11;
   localparam int OP_XNOR = 12, OP_SHL = 13, OP_SHR = 14, OP_CLR = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_op = 4'd0;
   logic [15:0] cmd_a = 16'd0;
   logic [15:0] cmd_b = 16'd0;
   logic        cmd_use_acc = 1'b0;
   logic        res_valid;
   logic [31:0] res_data;
   logic        err_ovf;
   logic        err_dz;
   logic        busy;

   typedef struct {
      logic [31:0] data;
      logic        ovf;
      logic        dz;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model_acc = 32'd0;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;

   alu_sequencer #(
      .WIDTH(16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_a       (cmd_a),
      .cmd_b       (cmd_b),
      .cmd_use_acc (cmd_use_acc),
      .res_valid   (res_valid),
      .res_data    (res_data),
      .err_ovf     (err_ovf),
      .err_dz      (err_dz),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(input int op, input logic [15:0] a, input logic [15:0] b);
      exp_t        e;
      logic [15:0] s;
      e.data = 32'd0;
      e.ovf  = 1'b0;
      e.dz   = 1'b0;
      case (op)
         OP_ADD: begin
            s = a + b;
            e.data = {{16{s[15]}}, s};
            e.ovf = (a[15] == b[15]) && (s[15] != a[15]);
         end
         OP_SUB: begin
            s = a - b;
            e.data = {{16{s[15]}}, s};
            e.ovf = (a[15] != b[15]) && (s[15] != a[15]);
         end
         OP_MUL:  e.data = {16'd0, a} * {16'd0, b};
         OP_DIV:  if (b == 16'd0) e.dz = 1'b1; else e.data = {16'd0, a / b};
         OP_MOD:  if (b == 16'd0) e.dz = 1'b1; else e.data = {16'd0, a % b};
         OP_AND:  e.data = {16'd0, a & b};
         OP_OR:   e.data = {16'd0, a | b};
         OP_XOR:  e.data = {16'd0, a ^ b};
         OP_NOT:  e.data = {16'd0, ~a};
         OP_NAND: e.data = {16'd0, ~(a & b)};
         OP_NOR:  e.data = {16'd0, ~(a | b)};
         OP_XNOR: e.data = {16'd0, ~(a ^ b)};
         OP_SHL:  e.data = {16'd0, a} << b[3:0];
         OP_SHR:  e.data = {16'd0, a >> b[3:0]};
         default: e.data = 32'd0;
      endcase
      return e;
   endfunction

   // Every res_valid pulse must match the oldest outstanding expectation.
   always @(posedge clk) begin
      #1;
      if (res_valid) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_res_valid: got res_valid=1 data=%h, required no result",
                     res_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (res_data !== e.data || err_ovf !== e.ovf || err_dz !== e.dz) begin
               bad++;
               $display("FAIL result: got data=%h ovf=%b dz=%b, required data=%h ovf=%b dz=%b",
                        res_data, err_ovf, err_dz, e.data, e.ovf, e.dz);
            end
         end
      end
   end

   task automatic issue(input int op, input logic [15:0] a, input logic [15:0] b,
                        input logic use_acc, output int acc_cyc);
      exp_t e;
      int   n = 0;
      e = model(op, use_acc ? model_acc[15:0] : a, b);
      cmd_op = 4'(op);
      cmd_a = a;
      cmd_b = b;
      cmd_use_acc = use_acc;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!cmd_ready) begin
         total++;
         bad++;
         $display("FAIL handshake_timeout: got cmd_ready=0 for 40 cycles, required 1");
         cmd_valid = 1'b0;
         acc_cyc = -1;
         return;
      end
      if (op != OP_NOP) begin
         sb.push_back(e);
         model_acc = e.data;
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_res(output int res_cyc);
      int n = 0;
      while (!res_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      res_cyc = res_valid ? cyc : -1000;
   endtask

   task automatic run_op(input string name, input int op, input logic [15:0] a,
                         input logic [15:0] b, input logic use_acc, input int lat);
      int c0, c1;
      issue(op, a, b, use_acc, c0);
      wait_res(c1);
      total++;
      if (c1 - c0 !== lat) begin
         bad++;
         $display("FAIL latency_%s: got %0d cycles, required %0d", name, c1 - c0, lat);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (res_data !== 32'd0 || res_valid !== 1'b0 || err_ovf !== 1'b0 || err_dz !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: got data=%h rv=%b ovf=%b dz=%b, required all zero",
                  res_data, res_valid, err_ovf, err_dz);
      end
      total++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_ready: got ready=%b busy=%b, required 1/0", cmd_ready, busy);
      end
      rst = 1'b0;
      model_acc = 32'd0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_add_sub();
      run_op("add_small", OP_ADD, 16'h0020, 16'h0020, 1'b0, 1);
      run_op("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 1);
      run_op("sub_neg", OP_SUB, 16'h0005, 16'h0007, 1'b0, 1);
      run_op("sub_ovf", OP_SUB, 16'h8000, 16'h0001, 1'b0, 1);
   endtask

   task automatic test_mul();
      int   c0, c1;
      logic ready_seen = 1'b0;
      issue(OP_MUL, 16'h000A, 16'h000A, 1'b0, c0);
      c1 = -1000;
      for (int k = 1; k <= 40; k++) begin
         if (k == 4) begin
            cmd_op = 4'(OP_ADD);
            cmd_valid = 1'b1;
         end
         if (k == 8) cmd_valid = 1'b0;
         @(posedge clk);
         #1;
         if (res_valid) begin
            c1 = cyc;
            break;
         end
         if (cmd_ready !== 1'b0 || busy !== 1'b1) ready_seen = 1'b1;
      end
      cmd_valid = 1'b0;
      total++;
      if (c1 - c0 !== 17) begin
         bad++;
         $display("FAIL latency_mul: got %0d cycles, required 17", c1 - c0);
      end
      total++;
      if (ready_seen !== 1'b0) begin
         bad++;
         $display("FAIL mul_busy: got cmd_ready=1 or busy=0 mid-op, required ready=0 busy=1");
      end
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (sb.size() !== 0) begin
         bad++;
         $display("FAIL mul_ignored_cmd: got %0d pending, required 0", sb.size());
      end
   endtask

   task automatic test_div();
      run_op("div", OP_DIV, 16'h0064, 16'h0007, 1'b0, 17);
      run_op("mod", OP_MOD, 16'h0064, 16'h0007, 1'b0, 17);
      run_op("div_zero", OP_DIV, 16'h0064, 16'h0000, 1'b0, 1);
      run_op("add_clears_dz", OP_ADD, 16'h0001, 16'h0001, 1'b0, 1);
      run_op("mod_zero", OP_MOD, 16'hFFFF, 16'h0000, 1'b0, 1);
      run_op("div_max", OP_DIV, 16'hFFFF, 16'h0001, 1'b0, 17);
   endtask

   task automatic test_chain();
      run_op("mul_max", OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0, 17);
      run_op("sub_acc", OP_SUB, 16'h1234, 16'h0001, 1'b1, 1);
      run_op("add_ovf2", OP_ADD, 16'h7FFF, 16'h7FFF, 1'b0, 1);
      run_op("clr", OP_CLR, 16'hAAAA, 16'h5555, 1'b0, 1);
      total++;
      if (res_data !== 32'd0 || err_ovf !== 1'b0 || err_dz !== 1'b0) begin
         bad++;
         $display("FAIL clr_state: got data=%h ovf=%b dz=%b, required zero",
                  res_data, err_ovf, err_dz);
      end
   endtask

   task automatic test_back_to_back();
      int c0, c1;
      for (int i = 0; i < 24; i++) begin
         int          op;
         logic [15:0] a, b;
         op = int'($urandom_range(0, 15));
         a = 16'($urandom);
         b = (i % 5 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
         issue(op, a, b, 1'($urandom_range(0, 1)), c0);
         if (op != OP_NOP) wait_res(c1);
      end
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (sb.size() !== 0) begin
         bad++;
         $display("FAIL b2b_drain: got %0d pending, required 0", sb.size());
      end
   endtask

   task automatic test_reset_mid();
      int c0;
      run_op("pre_reset_add", OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 1);
      issue(OP_MUL, 16'h0003, 16'h0005, 1'b0, c0);
      repeat (7) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (res_data !== 32'd0 || err_ovf !== 1'b0 || err_dz !== 1'b0 || res_valid !== 1'b0) begin
         bad++;
         $display("FAIL async_reset_outputs: got data=%h ovf=%b dz=%b rv=%b, required zero",
                  res_data, err_ovf, err_dz, res_valid);
      end
      total++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL async_reset_ready: got ready=%b busy=%b, required 1/0", cmd_ready, busy);
      end
      sb.delete();
      model_acc = 32'd0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (25) @(posedge clk);
      #1;
      total++;
      if (cmd_ready !== 1'b1 || res_data !== 32'd0) begin
         bad++;
         $display("FAIL post_reset_idle: got ready=%b data=%h, required 1/0", cmd_ready, res_data);
      end
      run_op("post_reset_acc", OP_ADD, 16'h9999, 16'h0002, 1'b1, 1);
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_mul();
      test_div();
      test_chain();
      test_back_to_back();
      test_reset_mid();
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (sb.size() !== 0) begin
         bad++;
         $display("FAIL final_drain: got %0d pending, required 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
